// File: rtl/apb_master_gen2_if.sv
// Command/response channel plus APB4 bus for apb_master_gen2.
// The master modport is the requester's view; slave is the environment's view.
interface apb_master_gen2_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_strb;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  busy;
  logic [ADDR_W-1:0]     paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
    input  paddr, psel, penable, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_gen2.sv
// APB4 requester: one command in, one APB transfer out, one-cycle response pulse.
// state  | meaning
// IDLE   | ready for a command, APB idle
// SETUP  | psel high, penable low, exactly one cycle
// ACCESS | penable high, waiting for pready or the wait-state timeout
module apb_master_gen2 #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  apb_master_gen2_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                pwrite_q, pwrite_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pwrite_d      = pwrite_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d   = bus.cmd_addr;
          pwrite_d  = bus.cmd_write;
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          pstrb_d   = bus.cmd_write ? bus.cmd_strb : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready wins over a timeout landing in the same cycle
        if (bus.pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
          state_d       = ST_IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = ST_IDLE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready   = (state_q == ST_IDLE) && rst;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.paddr       = paddr_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule
